// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counter library: FSM state encoding, the
//   width/modulus legality rule and the load-value clamp.
package counter_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   // A counter of 'width' bits can represent moduli 2 .. 2**width.
   function automatic bit params_legal(input int width, input longint unsigned modulus);
      return (width >= 1) && (width <= 32) &&
             (modulus >= 64'd2) && (modulus <= (64'd1 << width));
   endfunction

   // Load values outside the count range saturate to the top count.
   function automatic logic [31:0] clamp_load(input logic [31:0] d, input longint unsigned modulus);
      if ({32'd0, d} >= modulus) begin
         return 32'(modulus - 64'd1);
      end
      return d;
   endfunction

endpackage

// File: rtl/mod_n_step.sv
// mod_n_step
//   Combinational single-step of a modulo-MODULUS counter.
//   q       : current count (0..MODULUS-1)
//   up      : 1 = increment, 0 = decrement
//   nxt     : count after one step, wrapping at the terminal value
//   at_term : q is the terminal value for the requested direction
module mod_n_step #(
   parameter int              WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   output logic [WIDTH-1:0] nxt,
   output logic             at_term
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);

   always_comb begin
      at_term = up ? (q == TOP) : (q == '0);
      if (at_term) begin
         nxt = up ? '0 : TOP;
      end else if (up) begin
         nxt = q + WIDTH'(1);
      end else begin
         nxt = q - WIDTH'(1);
      end
   end

endmodule

// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter
//   Synchronous modulo-MODULUS up/down counter with enable, parallel load,
//   synchronous clear, cascadable terminal count and one-shot halt.
//   Clk     : clock, all state updates on posedge
//   Reset_n : asynchronous active-low reset (Q=0, RUN)
//   Clr     : synchronous clear, beats Load and counting
//   Load    : synchronous load of D (clamped to MODULUS-1), ignores En
//   D       : load value
//   En      : count enable / cascade carry-in
//   Up      : 1 = count up, 0 = count down
//   OneShot : 1 = halt at terminal value, 0 = wrap
//   Q       : current count
//   Tc      : combinational terminal count / carry-out
//   Done    : high while halted (registered FSM state)
module mod_n_updown_counter
   import counter_pkg::*;
#(
   parameter int              WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Clr,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             En,
   input  logic             Up,
   input  logic             OneShot,
   output logic [WIDTH-1:0] Q,
   output logic             Tc,
   output logic             Done
);

   if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
      $fatal(1, "mod_n_updown_counter: illegal WIDTH/MODULUS combination");
   end

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] step_nxt;
   logic             at_term;
   logic [WIDTH-1:0] load_val;

   mod_n_step #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_step (
      .q       (q_reg),
      .up      (Up),
      .nxt     (step_nxt),
      .at_term (at_term)
   );

   assign load_val = WIDTH'(clamp_load(32'(D), MODULUS));

   assign Q    = q_reg;
   assign Done = (state_reg == DONE);
   // Combinational so a following stage can use it directly as its En.
   assign Tc   = En & ~Done & at_term;

   always_comb begin
      q_next     = q_reg;
      state_next = state_reg;
      if (Clr) begin
         q_next     = '0;
         state_next = RUN;
      end else if (Load) begin
         q_next     = load_val;
         state_next = RUN;
      end else begin
         case (state_reg)
            RUN: begin
               if (En) begin
                  // One-shot entry freezes Q at the terminal value.
                  if (at_term && OneShot) begin
                     state_next = DONE;
                  end else begin
                     q_next = step_nxt;
                  end
               end
            end
            DONE: begin
               // Frozen until Clr, Load or reset.
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         q_reg     <= '0;
         state_reg <= RUN;
      end else begin
         q_reg     <= q_next;
         state_reg <= state_next;
      end
   end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb_mod_n_updown_counter
//   Scoreboard bench: a MODULUS=10 counter under directed and random stimulus,
//   a two-digit decimal cascade, and a 3-bit full-range down counter.
module tb_mod_n_updown_counter;

   typedef struct {
      int pre_q;
      int pre_done;
      int tc;
      int post_q;
      int post_done;
      int casc;
      int q3;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1, os = 1'b0;
   logic [3:0] d = 4'd0;
   logic [3:0] q;
   logic       tc, done;

   logic       casc_en = 1'b0;
   logic [3:0] q0, q1;
   logic       tc0, tc1, done0, done1;

   logic [2:0] q3;
   logic       tc3, done3;

   int vectors = 0;
   int miscompares = 0;

   exp_t sb[$];

   int m_q = 0, m_done = 0, m_casc = 0, m_q3 = 0;

   always #5 clk = ~clk;

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .Clk(clk), .Reset_n(rst_n), .Clr(clr), .Load(load), .D(d), .En(en),
      .Up(up), .OneShot(os), .Q(q), .Tc(tc), .Done(done)
   );

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_stage0 (
      .Clk(clk), .Reset_n(rst_n), .Clr(1'b0), .Load(1'b0), .D(4'd0), .En(casc_en),
      .Up(1'b1), .OneShot(1'b0), .Q(q0), .Tc(tc0), .Done(done0)
   );

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_stage1 (
      .Clk(clk), .Reset_n(rst_n), .Clr(1'b0), .Load(1'b0), .D(4'd0), .En(tc0),
      .Up(1'b1), .OneShot(1'b0), .Q(q1), .Tc(tc1), .Done(done1)
   );

   mod_n_updown_counter #(.WIDTH(3), .MODULUS(8)) u_w3 (
      .Clk(clk), .Reset_n(rst_n), .Clr(1'b0), .Load(1'b0), .D(3'd0), .En(1'b1),
      .Up(1'b0), .OneShot(1'b0), .Q(q3), .Tc(tc3), .Done(done3)
   );

   function automatic void chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
      end
   endfunction

   // Drive one cycle of inputs at the falling edge and push the expected
   // response from the arithmetic reference model.
   task automatic step(input int r, input int c, input int l, input int dv,
                       input int e, input int u, input int o, input int ce);
      exp_t x;
      int   term;
      @(negedge clk);
      rst_n = r[0]; clr = c[0]; load = l[0]; d = 4'(dv);
      en = e[0]; up = u[0]; os = o[0]; casc_en = ce[0];
      if (r == 0) begin
         m_q = 0; m_done = 0; m_casc = 0; m_q3 = 0;
      end
      term       = (u != 0) ? 9 : 0;
      x.pre_q    = m_q;
      x.pre_done = m_done;
      x.tc       = (e != 0 && m_done == 0 && m_q == term) ? 1 : 0;
      if (r == 0) begin
         // held in reset
      end else if (c != 0) begin
         m_q = 0; m_done = 0;
      end else if (l != 0) begin
         m_q = (dv > 9) ? 9 : dv; m_done = 0;
      end else if (e != 0 && m_done == 0) begin
         if (m_q == term && o != 0) m_done = 1;
         else m_q = (u != 0) ? (m_q + 1) % 10 : (m_q + 9) % 10;
      end
      if (r != 0 && ce != 0) m_casc = (m_casc + 1) % 100;
      if (r != 0) m_q3 = (m_q3 + 7) % 8;
      x.post_q    = m_q;
      x.post_done = m_done;
      x.casc      = m_casc;
      x.q3        = m_q3;
      sb.push_back(x);
   endtask

   // Monitor: check pre-edge view mid-cycle, post-edge view just after posedge.
   initial begin
      exp_t cur;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk("pre_q", int'(q), cur.pre_q);
            chk("pre_done", int'(done), cur.pre_done);
            chk("tc", int'(tc), cur.tc);
            @(posedge clk);
            #1;
            chk("q", int'(q), cur.post_q);
            chk("done", int'(done), cur.post_done);
            chk("q_in_range", (q <= 4'd9) ? 1 : 0, 1);
            chk("cascade", int'(q1) * 10 + int'(q0), cur.casc);
            chk("q3", int'(q3), cur.q3);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, c, l, ce;
      // reset held
      step(0, 0, 0, 0, 1, 1, 0, 1);
      step(0, 0, 0, 0, 1, 1, 0, 1);
      // wrap up: 12 edges, then down 3
      for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1, 1, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 0, 1);
      // one-shot from 7, then toggle Up while halted
      step(1, 0, 1, 7, 1, 1, 1, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 1, 1, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, i % 2, 1, 1);
      // load in DONE resumes counting
      step(1, 0, 1, 3, 1, 1, 1, 1);
      step(1, 0, 0, 0, 1, 1, 1, 1);
      // clamp, Clr+Load, Load beats En at terminal
      step(1, 0, 1, 13, 0, 1, 0, 1);
      step(1, 1, 1, 5, 1, 1, 0, 1);
      step(1, 0, 1, 9, 0, 1, 1, 1);
      step(1, 0, 1, 4, 1, 1, 1, 1);
      // async reset mid-cycle at Q=6
      step(1, 0, 1, 6, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 1, 0, 1);
      step(0, 0, 0, 0, 1, 1, 0, 1);
      // random phase; first 110 cycles uninterrupted for the cascade
      for (int i = 0; i < 320; i++) begin
         r  = (i < 110) ? 1 : (($urandom_range(49) != 0) ? 1 : 0);
         ce = (i < 110) ? 1 : (($urandom_range(3) != 0) ? 1 : 0);
         c  = ($urandom_range(19) == 0) ? 1 : 0;
         l  = ($urandom_range(9) == 0) ? 1 : 0;
         step(r, c, l, int'($urandom_range(15)), ($urandom_range(3) != 0) ? 1 : 0,
              int'($urandom_range(1)), int'($urandom_range(1)), ce);
      end
      @(posedge clk);
      #3;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
